mmc1_serial_mapper: RTL and testbench

Parametrised serial-load bank mapper core, a successor to the fixed MMC1 mapper. It decodes CPU writes to $8000–$FFFF through a serial shift port into four internal registers. From those registers it produces linear PRG/CHR addresses, the VRAM A10 line and the PRG-RAM enable. It adds three things the fixed mapper lacks: configurable bank widths, a revision-selectable PRG-RAM enable, and an optional free-running IRQ timer (NES-EVENT style). It sits between the cart bus and the cart memory router, as a drop-in for MMC1-family boards.

---
 rtl/mmc1_serial_mapper.sv | 176 +++++++++++++++++
 tb/tb_mmc1_serial_mapper.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmc1_serial_mapper.sv
// MMC1-family serial-load bank mapper: serial shift port into four bank registers,
// PRG/CHR linear address generation, CIRAM A10, PRG-RAM gating and an optional IRQ timer.
module mmc1_serial_mapper #(
    parameter int              PRG_BANK_W = 4,
    parameter int              CHR_BANK_W = 5,
    parameter int              REVISION   = 1,
    parameter int              OUTER_PRG  = 1,
    parameter int              RAM_BANK_W = 0,
    parameter int              IRQ_EN     = 0,
    parameter int              IRQ_W      = 30,
    parameter logic [IRQ_W-1:0] IRQ_TARGET = IRQ_W'(30'h2800000)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        enable,
    input  logic [1:0]  mirror_fixed,
    input  logic [15:0] prg_ain,
    input  logic        prg_write,
    input  logic [7:0]  prg_din,
    input  logic [13:0] chr_ain,
    output logic [21:0] prg_aout,
    output logic        prg_allow,
    output logic [21:0] chr_aout,
    output logic        vram_a10,
    output logic        vram_ce,
    output logic        irq
);

    typedef enum logic [1:0] {
        REG_CONTROL = 2'd0,
        REG_CHR0    = 2'd1,
        REG_CHR1    = 2'd2,
        REG_PRG     = 2'd3
    } reg_sel_t;

    localparam logic [4:0] SHIFT_EMPTY = 5'b10000;
    localparam logic [4:0] CHR_MASK    = 5'((1 << CHR_BANK_W) - 1);

    logic [4:0] shift_q;
    logic [4:0] control_q;
    logic [4:0] chr0_q;
    logic [4:0] chr1_q;
    logic [4:0] prg_q;
    logic       delay_q;

    logic       clear;
    logic       cpu_write;
    logic [4:0] shift_next;
    logic       unused_din;

    assign clear      = reset | ~enable;
    assign cpu_write  = ce & prg_write & prg_ain[15];
    assign shift_next = {prg_din[0], shift_q[4:1]};
    // Only bit7 (reset) and bit0 (serial data) of a CPU write carry meaning.
    assign unused_din = ^prg_din[6:1];

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the pre-edge values of its peers (shift_q vs. commit target).
    always_ff @(posedge clk) begin
        if (clear) begin
            shift_q   <= SHIFT_EMPTY;
            control_q <= 5'b01100;
            chr0_q    <= '0;
            chr1_q    <= '0;
            prg_q     <= '0;
            delay_q   <= 1'b0;
        end else if (ce) begin
            delay_q <= cpu_write;
            if (cpu_write) begin
                if (prg_din[7]) begin
                    shift_q   <= SHIFT_EMPTY;
                    control_q <= control_q | 5'b01100;
                end else if (!delay_q) begin
                    if (!shift_q[0]) begin
                        shift_q <= shift_next;
                    end else begin
                        // Marker bit reached bit0: this is the fifth bit, commit it.
                        shift_q <= SHIFT_EMPTY;
                        unique case (reg_sel_t'(prg_ain[14:13]))
                            REG_CONTROL: control_q <= shift_next;
                            REG_CHR0:    chr0_q    <= shift_next;
                            REG_CHR1:    chr1_q    <= shift_next;
                            REG_PRG:     prg_q     <= shift_next;
                        endcase
                    end
                end
            end
        end
    end

    logic [4:0]            chr_sel5;
    logic [4:0]            chrsel_ext;
    logic [CHR_BANK_W-1:0] chrsel;
    logic [PRG_BANK_W-1:0] prg_bank;
    logic [PRG_BANK_W-1:0] prgsel;
    logic                  outer_bit;
    logic [1:0]            ram_bank;
    logic [21:0]           rom_addr;
    logic [21:0]           ram_addr;
    logic                  ram_en;
    logic [1:0]            mirror_mode;

    // NOTE: every signal assigned in an always_comb gets a value on every path
    // (default or full case), otherwise synthesis infers a latch.
    always_comb begin
        if (control_q[4]) chr_sel5 = chr_ain[12] ? chr1_q : chr0_q;
        else              chr_sel5 = {chr0_q[4:1], chr_ain[12]};
    end

    assign chrsel_ext = chr_sel5 & CHR_MASK;
    assign chrsel     = chrsel_ext[CHR_BANK_W-1:0];
    assign prg_bank   = prg_q[PRG_BANK_W-1:0];

    always_comb begin
        unique case (control_q[3:2])
            2'b00, 2'b01: prgsel = {prg_bank[PRG_BANK_W-1:1], prg_ain[14]};
            2'b10:        prgsel = prg_ain[14] ? prg_bank : '0;
            default:      prgsel = prg_ain[14] ? '1 : prg_bank;
        endcase
    end

    always_comb begin
        if (RAM_BANK_W == 0)      ram_bank = 2'b00;
        else if (RAM_BANK_W == 1) ram_bank = {1'b0, chrsel_ext[2]};
        else                      ram_bank = chrsel_ext[3:2];
    end

    assign outer_bit = (OUTER_PRG != 0) ? chrsel_ext[4] : 1'b0;
    assign rom_addr  = 22'({outer_bit, prgsel, prg_ain[13:0]});
    assign ram_addr  = {7'b1111000, ram_bank, prg_ain[12:0]};
    assign prg_aout  = prg_ain[15] ? rom_addr : ram_addr;

    // MMC1A ignores prg[4]; MMC1B uses it as the PRG-RAM disable.
    assign ram_en    = (REVISION == 0) || !prg_q[4];
    assign prg_allow = prg_ain[15] ? ~prg_write : ((prg_ain[14:13] == 2'b11) && ram_en);

    assign chr_aout  = 22'({5'b10000, chrsel, chr_ain[11:0]});

    assign mirror_mode = (mirror_fixed != 2'b00) ? mirror_fixed : control_q[1:0];
    always_comb begin
        unique case (mirror_mode)
            2'd0:    vram_a10 = 1'b0;
            2'd1:    vram_a10 = 1'b1;
            2'd2:    vram_a10 = chr_ain[10];
            default: vram_a10 = chr_ain[11];
        endcase
    end

    assign vram_ce = chr_ain[13];

    generate
        if (IRQ_EN != 0) begin : g_irq
            logic [IRQ_W-1:0] cnt_q;
            logic             irq_q;

            always_ff @(posedge clk) begin
                if (clear) begin
                    cnt_q <= '0;
                    irq_q <= 1'b0;
                end else begin
                    irq_q <= (cnt_q >= IRQ_TARGET);
                    if (ce) begin
                        if (chr0_q[4])        cnt_q <= '0;
                        else if (cnt_q != '1) cnt_q <= cnt_q + IRQ_W'(1);
                    end
                end
            end

            assign irq = irq_q;
        end else begin : g_no_irq
            assign irq = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_mmc1_serial_mapper.sv
// Bench for mmc1_serial_mapper: two configurations driven in parallel, checked against
// a behavioural model that tracks the serial port as a bit count plus accumulator.
module tb_mmc1_serial_mapper;

    localparam int TGT  = 16;
    localparam int CMAX = 63;

    logic        clk = 1'b0;
    logic        reset, ce, enable, prg_write;
    logic [1:0]  mirror_fixed;
    logic [15:0] prg_ain;
    logic [7:0]  prg_din;
    logic [13:0] chr_ain;

    logic [21:0] a_prg_aout, a_chr_aout, b_prg_aout, b_chr_aout;
    logic        a_prg_allow, a_vram_a10, a_vram_ce, a_irq;
    logic        b_prg_allow, b_vram_a10, b_vram_ce, b_irq;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: register values as integers, serial progress as count + accumulator.
    int m_ctrl, m_chr0, m_chr1, m_prg, m_nbits, m_acc, m_cnt;
    bit m_armed, m_irq;

    always #5 clk = ~clk;

    mmc1_serial_mapper #(
        .REVISION(0), .OUTER_PRG(0), .RAM_BANK_W(1), .IRQ_EN(0)
    ) dut_a (
        .clk(clk), .reset(reset), .ce(ce), .enable(enable), .mirror_fixed(mirror_fixed),
        .prg_ain(prg_ain), .prg_write(prg_write), .prg_din(prg_din), .chr_ain(chr_ain),
        .prg_aout(a_prg_aout), .prg_allow(a_prg_allow), .chr_aout(a_chr_aout),
        .vram_a10(a_vram_a10), .vram_ce(a_vram_ce), .irq(a_irq)
    );

    mmc1_serial_mapper #(
        .REVISION(1), .OUTER_PRG(1), .RAM_BANK_W(2), .IRQ_EN(1), .IRQ_W(6),
        .IRQ_TARGET(6'd16)
    ) dut_b (
        .clk(clk), .reset(reset), .ce(ce), .enable(enable), .mirror_fixed(mirror_fixed),
        .prg_ain(prg_ain), .prg_write(prg_write), .prg_din(prg_din), .chr_ain(chr_ain),
        .prg_aout(b_prg_aout), .prg_allow(b_prg_allow), .chr_aout(b_chr_aout),
        .vram_a10(b_vram_a10), .vram_ce(b_vram_ce), .irq(b_irq)
    );

    task automatic model_step();
        bit wr;
        wr = ce && prg_write && prg_ain[15];
        if (reset || !enable) begin
            m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0;
            m_nbits = 0; m_acc = 0; m_armed = 0; m_cnt = 0; m_irq = 0;
        end else begin
            m_irq = (m_cnt >= TGT);
            if (ce) begin
                if ((m_chr0 & 16) != 0) m_cnt = 0;
                else if (m_cnt < CMAX)  m_cnt = m_cnt + 1;
                if (wr) begin
                    if (prg_din[7]) begin
                        m_nbits = 0; m_acc = 0; m_ctrl = m_ctrl | 12;
                    end else if (!m_armed) begin
                        m_acc   = m_acc + (prg_din[0] ? (1 << m_nbits) : 0);
                        m_nbits = m_nbits + 1;
                        if (m_nbits == 5) begin
                            case (int'(prg_ain[14:13]))
                                0: m_ctrl = m_acc;
                                1: m_chr0 = m_acc;
                                2: m_chr1 = m_acc;
                                default: m_prg = m_acc;
                            endcase
                            m_nbits = 0; m_acc = 0;
                        end
                    end
                end
                m_armed = wr;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic int e_chrsel();
        int a12;
        a12 = int'(chr_ain[12]);
        if ((m_ctrl & 16) != 0) return (a12 != 0) ? m_chr1 : m_chr0;
        return (m_chr0 & 30) | a12;
    endfunction

    function automatic logic [21:0] e_prg_aout(input int outer, input int ram_w);
        int a, hi, mode, bank, cs;
        a = int'(prg_ain); hi = (a >> 14) & 1; mode = (m_ctrl >> 2) & 3; cs = e_chrsel();
        if (a >= 'h8000) begin
            if (mode < 2)       bank = (m_prg & 14) | hi;
            else if (mode == 2) bank = (hi != 0) ? (m_prg & 15) : 0;
            else                bank = (hi != 0) ? 15 : (m_prg & 15);
            return 22'(bank * 16384 + (a % 16384) + ((outer != 0) ? ((cs >> 4) & 1) * 262144 : 0));
        end
        return 22'('h3C0000 + ((cs >> 2) & ((1 << ram_w) - 1)) * 8192 + (a % 8192));
    endfunction

    function automatic logic e_allow(input int rev);
        int a;
        a = int'(prg_ain);
        if (a >= 'h8000) return !prg_write;
        if (a >= 'h6000) return (rev == 0) || ((m_prg & 16) == 0);
        return 1'b0;
    endfunction

    function automatic logic e_a10();
        int eff;
        eff = (mirror_fixed != 0) ? int'(mirror_fixed) : (m_ctrl & 3);
        case (eff)
            0: return 1'b0;
            1: return 1'b1;
            2: return chr_ain[10];
            default: return chr_ain[11];
        endcase
    endfunction

    function automatic logic [21:0] e_chr_aout();
        return 22'('h200000 + e_chrsel() * 4096 + (int'(chr_ain) % 4096));
    endfunction

    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
        ce = 1'b1; prg_write = 1'b1; prg_ain = addr; prg_din = data;
        tick();
        prg_write = 1'b0;
        tick();
        ce = 1'b0;
    endtask

    task automatic serial_load(input logic [15:0] addr, input logic [4:0] val);
        for (int i = 0; i < 5; i++) cpu_write(addr, {7'b0, val[i]});
    endtask

    task automatic do_reset();
        reset = 1'b1; ce = 1'b0; prg_write = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; ce = 1'b1; prg_write = 1'b1;
        prg_ain = 16'h8000; prg_din = 8'h01;
        tick();
        reset = 1'b0; ce = 1'b0; prg_write = 1'b0;
        prg_ain = 16'hC000; chr_ain = 14'h1ABC; mirror_fixed = 2'd0;
        #1;
        n_checks++; if (a_prg_aout !== 22'h03C000) $display("FAIL reset_prg_last got %h want %h", a_prg_aout, 22'h03C000); else n_pass++;
        n_checks++; if (b_prg_aout !== 22'h03C000) $display("FAIL reset_prg_last_b got %h want %h", b_prg_aout, 22'h03C000); else n_pass++;
        n_checks++; if (a_chr_aout !== 22'h201ABC) $display("FAIL reset_chr got %h want %h", a_chr_aout, 22'h201ABC); else n_pass++;
        n_checks++; if (a_vram_a10 !== 1'b0) $display("FAIL reset_a10 got %b want 0", a_vram_a10); else n_pass++;
        n_checks++; if (b_irq !== 1'b0) $display("FAIL reset_irq got %b want 0", b_irq); else n_pass++;
        n_checks++; if (b_prg_allow !== 1'b1) $display("FAIL reset_allow got %b want 1", b_prg_allow); else n_pass++;
        // enable low behaves as reset
        serial_load(16'h8000, 5'b00011);
        chr_ain = 14'h0800; prg_ain = 16'hC000; #1;
        n_checks++; if (a_vram_a10 !== 1'b1) $display("FAIL ctrl_load_a10 got %b want 1", a_vram_a10); else n_pass++;
        enable = 1'b0; tick(); enable = 1'b1; #1;
        n_checks++; if (a_vram_a10 !== 1'b0) $display("FAIL enable_low_a10 got %b want 0", a_vram_a10); else n_pass++;
        n_checks++; if (a_prg_aout !== 22'h03C000) $display("FAIL enable_low_prg got %h want %h", a_prg_aout, 22'h03C000); else n_pass++;
        // reset mid-sequence discards partial shift
        cpu_write(16'hE000, 8'h01); cpu_write(16'hE000, 8'h01);
        do_reset();
        serial_load(16'hE000, 5'b00110);
        prg_ain = 16'h8000; #1;
        n_checks++; if (a_prg_aout !== 22'h018000) $display("FAIL reset_mid_seq got %h want %h", a_prg_aout, 22'h018000); else n_pass++;
    endtask

    task automatic test_serial_load();
        logic [4:0] bits;
        bits = 5'b01110;
        do_reset();
        for (int i = 0; i < 4; i++) cpu_write(16'hE000, {7'b0, bits[i]});
        prg_ain = 16'h8000; #1;
        n_checks++; if (b_prg_aout !== 22'h000000) $display("FAIL serial_before_5th got %h want %h", b_prg_aout, 22'h000000); else n_pass++;
        cpu_write(16'hE000, {7'b0, bits[4]});
        prg_ain = 16'h8000; #1;
        n_checks++; if (b_prg_aout !== 22'h038000) $display("FAIL serial_load_b got %h want %h", b_prg_aout, 22'h038000); else n_pass++;
        n_checks++; if (a_prg_aout !== 22'h038000) $display("FAIL serial_load_a got %h want %h", a_prg_aout, 22'h038000); else n_pass++;
    endtask

    task automatic test_double_write();
        do_reset();
        ce = 1'b1; prg_write = 1'b1; prg_ain = 16'hE000; prg_din = 8'h01;
        tick(); tick();
        prg_write = 1'b0; tick(); ce = 1'b0;
        for (int i = 0; i < 3; i++) cpu_write(16'hE000, 8'h00);
        prg_ain = 16'h8000; #1;
        n_checks++; if (b_prg_aout !== 22'h000000) $display("FAIL dbl_four_shifts got %h want %h", b_prg_aout, 22'h000000); else n_pass++;
        cpu_write(16'hE000, 8'h00);
        prg_ain = 16'h8000; #1;
        n_checks++; if (b_prg_aout !== 22'h004000) $display("FAIL dbl_commit got %h want %h", b_prg_aout, 22'h004000); else n_pass++;
        // idle cycles without ce keep the filter armed
        ce = 1'b1; prg_write = 1'b1; prg_ain = 16'hE000; prg_din = 8'h01; tick();
        ce = 1'b0; tick();
        ce = 1'b1; tick();
        prg_write = 1'b0; tick(); ce = 1'b0;
        cpu_write(16'hE000, 8'h00); cpu_write(16'hE000, 8'h00);
        cpu_write(16'hE000, 8'h00); cpu_write(16'hE000, 8'h01);
        prg_ain = 16'h8000; #1;
        n_checks++; if (b_prg_aout !== 22'h004000) $display("FAIL dbl_no_ce_hold got %h want %h", b_prg_aout, 22'h004000); else n_pass++;
        prg_ain = 16'h6000; #1;
        n_checks++; if (b_prg_allow !== 1'b0) $display("FAIL dbl_no_ce_ramdis got %b want 0", b_prg_allow); else n_pass++;
    endtask

    task automatic test_reset_write();
        do_reset();
        serial_load(16'h8000, 5'b00000);
        prg_ain = 16'hC000; #1;
        n_checks++; if (a_prg_aout !== 22'h004000) $display("FAIL rw_mode0 got %h want %h", a_prg_aout, 22'h004000); else n_pass++;
        for (int i = 0; i < 3; i++) cpu_write(16'hA000, 8'h01);
        cpu_write(16'h8000, 8'h80);
        prg_ain = 16'hC000; #1;
        n_checks++; if (a_prg_aout !== 22'h03C000) $display("FAIL rw_after_80 got %h want %h", a_prg_aout, 22'h03C000); else n_pass++;
        serial_load(16'h8000, 5'b00010);
        prg_ain = 16'hC000; chr_ain = 14'h0400; #1;
        n_checks++; if (a_prg_aout !== 22'h004000) $display("FAIL rw_ctrl_mode got %h want %h", a_prg_aout, 22'h004000); else n_pass++;
        n_checks++; if (a_vram_a10 !== 1'b1) $display("FAIL rw_a10_hi got %b want 1", a_vram_a10); else n_pass++;
        n_checks++; if (a_chr_aout !== 22'h200400) $display("FAIL rw_chr0_kept got %h want %h", a_chr_aout, 22'h200400); else n_pass++;
        chr_ain = 14'h0800; #1;
        n_checks++; if (a_vram_a10 !== 1'b0) $display("FAIL rw_a10_lo got %b want 0", a_vram_a10); else n_pass++;
        mirror_fixed = 2'd3; #1;
        n_checks++; if (a_vram_a10 !== 1'b1) $display("FAIL rw_mirror_fixed got %b want 1", a_vram_a10); else n_pass++;
        mirror_fixed = 2'd0;
        // reset write is accepted even right after another write
        ce = 1'b1; prg_write = 1'b1; prg_ain = 16'hA000; prg_din = 8'h01; tick();
        prg_ain = 16'h8000; prg_din = 8'h80; tick();
        prg_write = 1'b0; tick(); ce = 1'b0;
        prg_ain = 16'hC000; #1;
        n_checks++; if (a_prg_aout !== 22'h03C000) $display("FAIL rw_80_during_delay got %h want %h", a_prg_aout, 22'h03C000); else n_pass++;
    endtask

    task automatic test_prg_ram();
        do_reset();
        serial_load(16'hE000, 5'b10000);
        prg_ain = 16'h6000; #1;
        n_checks++; if (b_prg_allow !== 1'b0) $display("FAIL ram_rev1_dis got %b want 0", b_prg_allow); else n_pass++;
        n_checks++; if (a_prg_allow !== 1'b1) $display("FAIL ram_rev0_en got %b want 1", a_prg_allow); else n_pass++;
        prg_ain = 16'h7FFF; #1;
        n_checks++; if (b_prg_allow !== 1'b0) $display("FAIL ram_rev1_top got %b want 0", b_prg_allow); else n_pass++;
        serial_load(16'hA000, 5'b01100);
        prg_ain = 16'h6123; chr_ain = 14'h0000; #1;
        n_checks++; if (b_prg_aout !== 22'h3C6123) $display("FAIL ram_bank2 got %h want %h", b_prg_aout, 22'h3C6123); else n_pass++;
        n_checks++; if (a_prg_aout !== 22'h3C2123) $display("FAIL ram_bank1 got %h want %h", a_prg_aout, 22'h3C2123); else n_pass++;
        prg_ain = 16'h4000; #1;
        n_checks++; if (a_prg_allow !== 1'b0) $display("FAIL ram_below_window got %b want 0", a_prg_allow); else n_pass++;
        prg_ain = 16'h8000; prg_write = 1'b1; #1;
        n_checks++; if (a_prg_allow !== 1'b0) $display("FAIL rom_write_allow got %b want 0", a_prg_allow); else n_pass++;
        prg_write = 1'b0; #1;
        n_checks++; if (a_prg_allow !== 1'b1) $display("FAIL rom_read_allow got %b want 1", a_prg_allow); else n_pass++;
        serial_load(16'hE000, 5'b00000);
        prg_ain = 16'h6000; #1;
        n_checks++; if (b_prg_allow !== 1'b1) $display("FAIL ram_rev1_en got %b want 1", b_prg_allow); else n_pass++;
    endtask

    task automatic test_surom();
        do_reset();
        serial_load(16'hA000, 5'b10000);
        prg_ain = 16'hC000; chr_ain = 14'h1234; #1;
        n_checks++; if (b_prg_aout !== 22'h07C000) $display("FAIL surom_outer got %h want %h", b_prg_aout, 22'h07C000); else n_pass++;
        n_checks++; if (a_prg_aout !== 22'h03C000) $display("FAIL surom_no_outer got %h want %h", a_prg_aout, 22'h03C000); else n_pass++;
        n_checks++; if (b_chr_aout !== 22'h211234) $display("FAIL surom_chr got %h want %h", b_chr_aout, 22'h211234); else n_pass++;
        prg_ain = 16'h8000; #1;
        n_checks++; if (b_prg_aout !== 22'h040000) $display("FAIL surom_8000 got %h want %h", b_prg_aout, 22'h040000); else n_pass++;
    endtask

    task automatic test_irq();
        do_reset();
        ce = 1'b1; prg_write = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        n_checks++; if (b_irq !== 1'b0) $display("FAIL irq_early got %b want 0", b_irq); else n_pass++;
        ce = 1'b0; tick();
        n_checks++; if (b_irq !== 1'b1) $display("FAIL irq_rise got %b want 1", b_irq); else n_pass++;
        n_checks++; if (a_irq !== 1'b0) $display("FAIL irq_disabled got %b want 0", a_irq); else n_pass++;
        ce = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            n_checks++; if (b_irq !== 1'b1) $display("FAIL irq_saturate cycle %0d got %b want 1", i, b_irq); else n_pass++;
        end
        serial_load(16'hA000, 5'b10000);
        n_checks++; if (b_irq !== 1'b1) $display("FAIL irq_before_fall got %b want 1", b_irq); else n_pass++;
        ce = 1'b1; tick();
        n_checks++; if (b_irq !== 1'b0) $display("FAIL irq_fall got %b want 0", b_irq); else n_pass++;
        for (int i = 0; i < 30; i++) tick();
        n_checks++; if (b_irq !== 1'b0) $display("FAIL irq_held_clear got %b want 0", b_irq); else n_pass++;
        ce = 1'b0;
    endtask

    task automatic test_random();
        logic [21:0] ep_a, ep_b, ec;
        logic        eal_a, eal_b, ea10;
        int          r;
        do_reset();
        for (int it = 0; it < 700; it++) begin
            reset     = ($urandom_range(0, 149) == 0);
            enable    = ($urandom_range(0, 149) != 0);
            ce        = ($urandom_range(0, 3) != 0);
            prg_write = ($urandom_range(0, 1) == 0);
            r = $urandom_range(0, 7);
            if (r == 0)      prg_ain = 16'($urandom);
            else if (r < 3)  prg_ain = 16'h6000 | 16'($urandom_range(0, 16'h1FFF));
            else             prg_ain = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
            prg_din   = ($urandom_range(0, 31) == 0) ? 8'h80 : {1'b0, 7'($urandom)};
            chr_ain   = 14'($urandom);
            r = $urandom_range(0, 3);
            mirror_fixed = (r < 2) ? 2'd0 : 2'(r);
            #1;
            ep_a = e_prg_aout(0, 1); ep_b = e_prg_aout(1, 2); ec = e_chr_aout();
            eal_a = e_allow(0); eal_b = e_allow(1); ea10 = e_a10();
            n_checks++; if (a_prg_aout !== ep_a) $display("FAIL rnd_prg_a it %0d got %h want %h", it, a_prg_aout, ep_a); else n_pass++;
            n_checks++; if (b_prg_aout !== ep_b) $display("FAIL rnd_prg_b it %0d got %h want %h", it, b_prg_aout, ep_b); else n_pass++;
            n_checks++; if (a_chr_aout !== ec) $display("FAIL rnd_chr_a it %0d got %h want %h", it, a_chr_aout, ec); else n_pass++;
            n_checks++; if (b_chr_aout !== ec) $display("FAIL rnd_chr_b it %0d got %h want %h", it, b_chr_aout, ec); else n_pass++;
            n_checks++; if (a_prg_allow !== eal_a) $display("FAIL rnd_allow_a it %0d got %b want %b", it, a_prg_allow, eal_a); else n_pass++;
            n_checks++; if (b_prg_allow !== eal_b) $display("FAIL rnd_allow_b it %0d got %b want %b", it, b_prg_allow, eal_b); else n_pass++;
            n_checks++; if (a_vram_a10 !== ea10) $display("FAIL rnd_a10 it %0d got %b want %b", it, a_vram_a10, ea10); else n_pass++;
            n_checks++; if (b_vram_ce !== chr_ain[13]) $display("FAIL rnd_vram_ce it %0d got %b want %b", it, b_vram_ce, chr_ain[13]); else n_pass++;
            n_checks++; if (b_irq !== m_irq) $display("FAIL rnd_irq it %0d got %b want %b", it, b_irq, m_irq); else n_pass++;
            tick();
        end
        reset = 1'b0; enable = 1'b1; ce = 1'b0; prg_write = 1'b0; mirror_fixed = 2'd0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; ce = 1'b0; prg_write = 1'b0;
        mirror_fixed = 2'd0; prg_ain = 16'h0000; prg_din = 8'h00; chr_ain = 14'h0000;
        test_reset();
        test_serial_load();
        test_double_write();
        test_reset_write();
        test_prg_ram();
        test_surom();
        test_irq();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
